// File: rtl/audio_regs_bank.sv
// rtl/audio_regs_bank.sv - AudioNet control/status register bank
//
// Purpose:
//   Bus-mapped control/status registers for the AudioNet datapath. A single
//   request per cycle on the val/ready bus is answered exactly one cycle later.
//   The bank holds the TDM2P control and payload snapshot, the P2TDM control,
//   a staged P2TDM payload with a commit strobe, saturating read-to-clear event
//   counters, W1C sticky status with a maskable interrupt, per-channel
//   gain/balance and the TDM mux select.
//
// Ports:
//   clk_i, rst_i                    clock, asynchronous active-high reset
//   val_i, addr_i, write_i, wdata_i bus request (byte address, [1:0] ignored)
//   rdata_o, ready_o                bus response, rdata_o is 0 unless a read completes
//   tdm2p_enable_o, tdm2p_clk_*_o   TDM2P control fields
//   tdm2p_valid_i, tdm2p_pdata_i    TDM2P payload feeding the snapshot
//   p2tdm_enable_o                  P2TDM enable
//   retrans_incr_i, dropped_incr_i  event pulses for the two counters
//   p2tdm_valid_o, p2tdm_pdata_o    committed P2TDM payload and one-cycle strobe
//   gain_o, bal_o                   per-channel gain (16b) and balance (8b)
//   sel_o                           TDM mux select
//   irq_o                           registered OR of enabled status bits

module audio_regs_bank #(
  parameter int NUM_CH  = 4,
  parameter int PDATA_W = 256,
  parameter int CNT_W   = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   val_i,
  input  logic [9:0]             addr_i,
  input  logic                   write_i,
  input  logic [31:0]            wdata_i,
  output logic [31:0]            rdata_o,
  output logic                   ready_o,
  output logic                   tdm2p_enable_o,
  output logic [7:0]             tdm2p_clk_mask_o,
  output logic [7:0]             tdm2p_clk_patt_o,
  input  logic                   tdm2p_valid_i,
  input  logic [PDATA_W-1:0]     tdm2p_pdata_i,
  output logic                   p2tdm_enable_o,
  input  logic                   retrans_incr_i,
  input  logic                   dropped_incr_i,
  output logic                   p2tdm_valid_o,
  output logic [PDATA_W-1:0]     p2tdm_pdata_o,
  output logic [NUM_CH*16-1:0]   gain_o,
  output logic [NUM_CH*8-1:0]    bal_o,
  output logic                   sel_o,
  output logic                   irq_o
);

  localparam int NW = PDATA_W / 32;

  // Word addresses (byte address >> 2)
  localparam logic [7:0] W_TDM2P_CTRL = 8'h00;
  localparam logic [7:0] W_SNAP0      = 8'h04;
  localparam logic [7:0] W_P2TDM_CTRL = 8'h40;
  localparam logic [7:0] W_CNT        = 8'h41;
  localparam logic [7:0] W_STATUS     = 8'h42;
  localparam logic [7:0] W_IRQ_EN     = 8'h43;
  localparam logic [7:0] W_STAGE0     = 8'h44;
  localparam logic [7:0] W_COMMIT     = 8'h7C;
  localparam logic [7:0] W_CH0        = 8'h80;
  localparam logic [7:0] W_SEL        = 8'hC0;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [31:0]      UNMAPPED = 32'hBADACE55;

  logic [7:0] word;
  logic       wr_en;
  logic       rd_en;
  logic       unused_addr_bits;

  logic             tdm2p_en_q, tdm2p_en_d;
  logic             freeze_q, freeze_d;
  logic [7:0]       clk_mask_q, clk_mask_d;
  logic [7:0]       clk_patt_q, clk_patt_d;
  logic [31:0]      snap_q [NW];
  logic [31:0]      snap_d [NW];
  logic             p2tdm_en_q, p2tdm_en_d;
  logic [CNT_W-1:0] retrans_cnt_q, retrans_cnt_d;
  logic [CNT_W-1:0] dropped_cnt_q, dropped_cnt_d;
  logic [1:0]       status_q, status_d;
  logic [1:0]       irq_en_q, irq_en_d;
  logic [31:0]      stage_q [NW];
  logic [31:0]      stage_d [NW];
  logic             p2tdm_valid_q, p2tdm_valid_d;
  logic [PDATA_W-1:0] p2tdm_pdata_q, p2tdm_pdata_d;
  logic [PDATA_W-1:0] stage_flat;
  logic [23:0]      ch_q [NUM_CH];
  logic [23:0]      ch_d [NUM_CH];
  logic             sel_q, sel_d;
  logic             irq_q, irq_d;
  logic             ready_q, ready_d;
  logic [31:0]      rdata_q, rdata_d;

  logic [31:0]      rd_mux;
  logic             cnt_clr;
  logic             ret_sat, drop_sat;
  logic [CNT_W-1:0] ret_base, drop_base;
  logic [15:0]      ret16, drop16;

  assign word             = addr_i[9:2];
  assign unused_addr_bits = ^addr_i[1:0];
  assign wr_en            = val_i & write_i;
  assign rd_en            = val_i & ~write_i;

  for (genvar k = 0; k < NW; k++) begin : g_stage_flat
    assign stage_flat[32*k +: 32] = stage_q[k];
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch_out
    assign gain_o[16*c +: 16] = ch_q[c][15:0];
    assign bal_o[8*c +: 8]    = ch_q[c][23:16];
  end

  // Zero-extended counter views for the CNT word
  always_comb begin
    ret16                = '0;
    drop16               = '0;
    ret16[CNT_W-1:0]     = retrans_cnt_q;
    drop16[CNT_W-1:0]    = dropped_cnt_q;
  end

  // Read mux: always reflects register state before this cycle's updates,
  // so a same-cycle capture/increment is not visible in the returned word.
  always_comb begin
    rd_mux = UNMAPPED;
    if (word == W_TDM2P_CTRL) rd_mux = {tdm2p_en_q, 14'b0, freeze_q, clk_mask_q, clk_patt_q};
    if (word == W_P2TDM_CTRL) rd_mux = {p2tdm_en_q, 31'b0};
    if (word == W_CNT)        rd_mux = {ret16, drop16};
    if (word == W_STATUS)     rd_mux = {30'b0, status_q};
    if (word == W_IRQ_EN)     rd_mux = {30'b0, irq_en_q};
    if (word == W_COMMIT)     rd_mux = 32'b0;
    if (word == W_SEL)        rd_mux = {31'b0, sel_q};
    for (int k = 0; k < NW; k++) begin
      if (word == W_SNAP0 + 8'(k))  rd_mux = snap_q[k];
      if (word == W_STAGE0 + 8'(k)) rd_mux = stage_q[k];
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (word == W_CH0 + 8'(c)) rd_mux = {8'b0, ch_q[c]};
    end
  end

  // Saturating event counters. A CNT read clears both counters; an increment
  // in the same cycle then lands on the cleared value.
  always_comb begin
    cnt_clr   = rd_en && (word == W_CNT);
    ret_sat   = 1'b0;
    drop_sat  = 1'b0;
    ret_base  = cnt_clr ? '0 : retrans_cnt_q;
    drop_base = cnt_clr ? '0 : dropped_cnt_q;
    retrans_cnt_d = ret_base;
    dropped_cnt_d = drop_base;
    if (retrans_incr_i) begin
      if (ret_base == CNT_MAX) ret_sat = 1'b1;
      else                     retrans_cnt_d = ret_base + 1'b1;
    end
    if (dropped_incr_i) begin
      if (drop_base == CNT_MAX) drop_sat = 1'b1;
      else                      dropped_cnt_d = drop_base + 1'b1;
    end
  end

  always_comb begin
    tdm2p_en_d    = tdm2p_en_q;
    freeze_d      = freeze_q;
    clk_mask_d    = clk_mask_q;
    clk_patt_d    = clk_patt_q;
    p2tdm_en_d    = p2tdm_en_q;
    irq_en_d      = irq_en_q;
    sel_d         = sel_q;
    p2tdm_valid_d = 1'b0;
    p2tdm_pdata_d = p2tdm_pdata_q;
    for (int k = 0; k < NW; k++) begin
      stage_d[k] = stage_q[k];
      // Whole payload is captured in one edge, so freeze holds all words together
      snap_d[k]  = (tdm2p_valid_i && !freeze_q) ? tdm2p_pdata_i[32*k +: 32] : snap_q[k];
    end
    for (int c = 0; c < NUM_CH; c++) begin
      ch_d[c] = ch_q[c];
    end

    // Sticky status: a new saturation event wins over a same-cycle W1C
    status_d = status_q;
    if (wr_en && (word == W_STATUS)) status_d = status_q & ~wdata_i[1:0];
    status_d = status_d | {drop_sat, ret_sat};

    if (wr_en) begin
      if (word == W_TDM2P_CTRL) begin
        tdm2p_en_d = wdata_i[31];
        freeze_d   = wdata_i[16];
        clk_mask_d = wdata_i[15:8];
        clk_patt_d = wdata_i[7:0];
      end
      if (word == W_P2TDM_CTRL) p2tdm_en_d = wdata_i[31];
      if (word == W_IRQ_EN)     irq_en_d   = wdata_i[1:0];
      if (word == W_SEL)        sel_d      = wdata_i[0];
      if (word == W_COMMIT) begin
        p2tdm_valid_d = 1'b1;
        p2tdm_pdata_d = stage_flat;
      end
      for (int k = 0; k < NW; k++) begin
        if (word == W_STAGE0 + 8'(k)) stage_d[k] = wdata_i;
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if (word == W_CH0 + 8'(c)) ch_d[c] = wdata_i[23:0];
      end
    end

    irq_d   = |(status_q & irq_en_q);
    ready_d = val_i;
    rdata_d = rd_en ? rd_mux : 32'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tdm2p_en_q    <= 1'b0;
      freeze_q      <= 1'b0;
      clk_mask_q    <= '0;
      clk_patt_q    <= '0;
      p2tdm_en_q    <= 1'b0;
      retrans_cnt_q <= '0;
      dropped_cnt_q <= '0;
      status_q      <= '0;
      irq_en_q      <= '0;
      p2tdm_valid_q <= 1'b0;
      p2tdm_pdata_q <= '0;
      sel_q         <= 1'b0;
      irq_q         <= 1'b0;
      ready_q       <= 1'b0;
      rdata_q       <= '0;
      for (int k = 0; k < NW; k++) begin
        snap_q[k]  <= '0;
        stage_q[k] <= '0;
      end
      for (int c = 0; c < NUM_CH; c++) begin
        ch_q[c] <= '0;
      end
    end else begin
      tdm2p_en_q    <= tdm2p_en_d;
      freeze_q      <= freeze_d;
      clk_mask_q    <= clk_mask_d;
      clk_patt_q    <= clk_patt_d;
      p2tdm_en_q    <= p2tdm_en_d;
      retrans_cnt_q <= retrans_cnt_d;
      dropped_cnt_q <= dropped_cnt_d;
      status_q      <= status_d;
      irq_en_q      <= irq_en_d;
      p2tdm_valid_q <= p2tdm_valid_d;
      p2tdm_pdata_q <= p2tdm_pdata_d;
      sel_q         <= sel_d;
      irq_q         <= irq_d;
      ready_q       <= ready_d;
      rdata_q       <= rdata_d;
      for (int k = 0; k < NW; k++) begin
        snap_q[k]  <= snap_d[k];
        stage_q[k] <= stage_d[k];
      end
      for (int c = 0; c < NUM_CH; c++) begin
        ch_q[c] <= ch_d[c];
      end
    end
  end

  assign rdata_o          = rdata_q;
  assign ready_o          = ready_q;
  assign tdm2p_enable_o   = tdm2p_en_q;
  assign tdm2p_clk_mask_o = clk_mask_q;
  assign tdm2p_clk_patt_o = clk_patt_q;
  assign p2tdm_enable_o   = p2tdm_en_q;
  assign p2tdm_valid_o    = p2tdm_valid_q;
  assign p2tdm_pdata_o    = p2tdm_pdata_q;
  assign sel_o            = sel_q;
  assign irq_o            = irq_q;

endmodule

// File: tb/tb_audio_regs_bank.sv
// tb/tb_audio_regs_bank.sv - self-checking bench for audio_regs_bank
module tb_audio_regs_bank;

  localparam int NUM_CH  = 4;
  localparam int PDATA_W = 256;
  localparam int CNT_W   = 4;
  localparam int NW      = PDATA_W / 32;
  localparam int CMAX    = (1 << CNT_W) - 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 val, write;
  logic [9:0]           addr;
  logic [31:0]          wdata;
  logic [31:0]          rdata;
  logic                 ready;
  logic                 tdm2p_enable;
  logic [7:0]           tdm2p_clk_mask, tdm2p_clk_patt;
  logic                 tdm2p_valid;
  logic [PDATA_W-1:0]   tdm2p_pdata;
  logic                 p2tdm_enable;
  logic                 retrans_incr, dropped_incr;
  logic                 p2tdm_valid;
  logic [PDATA_W-1:0]   p2tdm_pdata;
  logic [NUM_CH*16-1:0] gain;
  logic [NUM_CH*8-1:0]  bal;
  logic                 sel, irq;

  audio_regs_bank #(.NUM_CH(NUM_CH), .PDATA_W(PDATA_W), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst), .val_i(val), .addr_i(addr), .write_i(write),
    .wdata_i(wdata), .rdata_o(rdata), .ready_o(ready),
    .tdm2p_enable_o(tdm2p_enable), .tdm2p_clk_mask_o(tdm2p_clk_mask),
    .tdm2p_clk_patt_o(tdm2p_clk_patt), .tdm2p_valid_i(tdm2p_valid),
    .tdm2p_pdata_i(tdm2p_pdata), .p2tdm_enable_o(p2tdm_enable),
    .retrans_incr_i(retrans_incr), .dropped_incr_i(dropped_incr),
    .p2tdm_valid_o(p2tdm_valid), .p2tdm_pdata_o(p2tdm_pdata),
    .gain_o(gain), .bal_o(bal), .sel_o(sel), .irq_o(irq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: register file by word address plus abstract state
  logic [31:0] m_rw [0:255];
  logic [31:0] m_snap [NW];
  logic [31:0] m_pdata [NW];
  logic [1:0]  m_status;
  int          m_ret, m_drop;
  logic [31:0] last_rdata;

  task automatic m_reset();
    for (int i = 0; i < 256; i++) m_rw[i] = '0;
    for (int k = 0; k < NW; k++) begin
      m_snap[k]  = '0;
      m_pdata[k] = '0;
    end
    m_status = '0;
    m_ret    = 0;
    m_drop   = 0;
  endtask

  function automatic logic [31:0] rw_mask(input int a);
    if (a == 32'h000) return 32'h8001FFFF;
    if (a == 32'h100) return 32'h80000000;
    if (a == 32'h10C) return 32'h00000003;
    if (a >= 32'h110 && a < 32'h110 + 4*NW) return 32'hFFFFFFFF;
    if (a >= 32'h200 && a < 32'h200 + 4*NUM_CH) return 32'h00FFFFFF;
    if (a == 32'h300) return 32'h00000001;
    return 32'h0;
  endfunction

  function automatic logic [31:0] m_read(input int a);
    if (rw_mask(a) != 0) return m_rw[a >> 2];
    if (a >= 32'h010 && a < 32'h010 + 4*NW) return m_snap[(a - 32'h010) / 4];
    if (a == 32'h104) return {16'(m_ret), 16'(m_drop)};
    if (a == 32'h108) return {30'b0, m_status};
    if (a == 32'h1F0) return 32'h0;
    return 32'hBADACE55;
  endfunction

  // One bus cycle: drive at negedge, advance model, check at next negedge
  task automatic step(input bit v, input bit w, input logic [9:0] a, input logic [31:0] d,
                      input bit ri, input bit di, input bit tv, input logic [PDATA_W-1:0] td);
    int          aw;
    logic [31:0] exp_rd;
    bit          exp_rdy, exp_pv, exp_irq;
    logic [1:0]  set_b;
    logic [NUM_CH*16-1:0] eg;
    logic [NUM_CH*8-1:0]  eb;
    aw = int'(a) & ~3;
    val = v; write = w; addr = a; wdata = d;
    retrans_incr = ri; dropped_incr = di; tdm2p_valid = tv; tdm2p_pdata = td;

    exp_rdy = v;
    exp_rd  = (v && !w) ? m_read(aw) : 32'h0;
    exp_irq = |(m_status & m_rw[32'h10C >> 2][1:0]);

    set_b = 2'b00;
    if (v && !w && aw == 32'h104) begin
      m_ret  = ri ? 1 : 0;
      m_drop = di ? 1 : 0;
    end else begin
      if (ri) begin
        if (m_ret == CMAX) set_b[0] = 1'b1;
        else m_ret++;
      end
      if (di) begin
        if (m_drop == CMAX) set_b[1] = 1'b1;
        else m_drop++;
      end
    end
    if (v && w && aw == 32'h108) m_status = m_status & ~d[1:0];
    m_status = m_status | set_b;

    if (tv && !m_rw[0][16])
      for (int k = 0; k < NW; k++) m_snap[k] = td[32*k +: 32];

    exp_pv = 1'b0;
    if (v && w) begin
      if (aw == 32'h1F0) begin
        exp_pv = 1'b1;
        for (int k = 0; k < NW; k++) m_pdata[k] = m_rw[(32'h110 >> 2) + k];
      end
      if (rw_mask(aw) != 0) m_rw[aw >> 2] = d & rw_mask(aw);
    end

    @(negedge clk);
    last_rdata = rdata;
    chk("ready", ready, exp_rdy);
    chk("rdata", rdata, exp_rd);
    chk("irq", irq, exp_irq);
    chk("p2tdm_valid", p2tdm_valid, exp_pv);
    chk("tdm2p_enable", tdm2p_enable, m_rw[0][31]);
    chk("tdm2p_clk_mask", tdm2p_clk_mask, m_rw[0][15:8]);
    chk("tdm2p_clk_patt", tdm2p_clk_patt, m_rw[0][7:0]);
    chk("p2tdm_enable", p2tdm_enable, m_rw[32'h100 >> 2][31]);
    chk("sel", sel, m_rw[32'h300 >> 2][0]);
    for (int c = 0; c < NUM_CH; c++) begin
      eg[16*c +: 16] = m_rw[(32'h200 >> 2) + c][15:0];
      eb[8*c +: 8]   = m_rw[(32'h200 >> 2) + c][23:16];
    end
    chk("gain", 64'(gain), 64'(eg));
    chk("bal", 64'(bal), 64'(eb));
    for (int k = 0; k < NW; k++) chk("p2tdm_pdata", p2tdm_pdata[32*k +: 32], m_pdata[k]);
  endtask

  task automatic idle(input bit ri, input bit di);
    step(1'b0, 1'b0, 10'h0, 32'h0, ri, di, 1'b0, '0);
  endtask

  task automatic wr(input logic [9:0] a, input logic [31:0] d);
    step(1'b1, 1'b1, a, d, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic rd(input logic [9:0] a);
    step(1'b1, 1'b0, a, 32'h0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  function automatic logic [9:0] rand_addr();
    int a;
    case ($urandom_range(0, 11))
      0:       a = 32'h000;
      1:       a = 32'h010 + 4 * int'($urandom_range(0, NW - 1));
      2:       a = 32'h100;
      3, 11:   a = 32'h104;
      4:       a = 32'h108;
      5:       a = 32'h10C;
      6:       a = 32'h110 + 4 * int'($urandom_range(0, NW - 1));
      7:       a = 32'h1F0;
      8:       a = 32'h200 + 4 * int'($urandom_range(0, NUM_CH));
      9:       a = 32'h300;
      default: a = 4 * int'($urandom_range(0, 255));
    endcase
    return 10'(a | int'($urandom_range(0, 3)));
  endfunction

  logic [PDATA_W-1:0] td_a, td_b, td_r;

  initial begin
    rst = 1'b1; val = 0; write = 0; addr = '0; wdata = '0;
    retrans_incr = 0; dropped_incr = 0; tdm2p_valid = 0; tdm2p_pdata = '0;
    m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", ready, 1'b0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_irq", irq, 1'b0);
    chk("rst_pvalid", p2tdm_valid, 1'b0);
    rst = 1'b0;
    idle(0, 0);

    // TDM2P control write/readback
    wr(10'h000, 32'h8001A55A);
    rd(10'h000);
    chk("ctrl_rd", last_rdata, 32'h8001A55A);
    chk("ctrl_en", tdm2p_enable, 1'b1);
    chk("ctrl_mask", tdm2p_clk_mask, 8'hA5);
    chk("ctrl_patt", tdm2p_clk_patt, 8'h5A);
    wr(10'h000, 32'h0);

    // Counter read-to-clear
    repeat (3) idle(1, 0);
    rd(10'h104);
    chk("cnt_rd1", last_rdata, 32'h00030000);
    rd(10'h104);
    chk("cnt_rd2", last_rdata, 32'h0);

    // Saturation, sticky status, irq
    wr(10'h10C, 32'h2);
    repeat (17) idle(0, 1);
    rd(10'h104);
    chk("cnt_sat", last_rdata, 32'h0000000F);
    idle(0, 0);
    chk("irq_set", irq, 1'b1);
    rd(10'h108);
    chk("status_rd", last_rdata, 32'h2);
    wr(10'h108, 32'h2);
    idle(0, 0);
    idle(0, 0);
    chk("irq_clr", irq, 1'b0);

    // Stage and commit
    for (int k = 0; k < NW; k++) wr(10'(32'h110 + 4*k), 32'(k + 1));
    wr(10'h1F0, 32'h0);
    chk("commit_valid", p2tdm_valid, 1'b1);
    chk("commit_w0", p2tdm_pdata[31:0], 32'h1);
    chk("commit_w7", p2tdm_pdata[255:224], 32'h8);
    idle(0, 0);
    chk("commit_pulse", p2tdm_valid, 1'b0);

    // Snapshot freeze
    for (int k = 0; k < NW; k++) begin
      td_a[32*k +: 32] = $urandom;
      td_b[32*k +: 32] = $urandom;
    end
    step(0, 0, 10'h0, 32'h0, 0, 0, 1, td_a);
    wr(10'h000, 32'h00010000);
    step(0, 0, 10'h0, 32'h0, 0, 0, 1, td_b);
    rd(10'h010);
    chk("snap_frozen_w0", last_rdata, td_a[31:0]);
    rd(10'h02C);
    chk("snap_frozen_w7", last_rdata, td_a[255:224]);
    wr(10'h000, 32'h0);
    step(0, 0, 10'h0, 32'h0, 0, 0, 1, td_b);
    rd(10'h010);
    chk("snap_new_w0", last_rdata, td_b[31:0]);

    // Channel register and unmapped channel
    wr(10'h20C, 32'h00407FFF);
    rd(10'h20C);
    chk("ch3_rd", last_rdata, 32'h00407FFF);
    chk("ch3_gain", gain[63:48], 16'h7FFF);
    chk("ch3_bal", bal[31:24], 8'h40);
    rd(10'h210);
    chk("ch4_unmapped", last_rdata, 32'hBADACE55);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      for (int k = 0; k < NW; k++) td_r[32*k +: 32] = $urandom;
      step($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, rand_addr(), $urandom,
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 2) == 0, td_r);
    end

    // Reset during an accepted read: no response
    val = 1'b1; write = 1'b0; addr = 10'h000; rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_ready", ready, 1'b0);
    chk("rst_mid_rdata", rdata, 32'h0);
    val = 1'b0; rst = 1'b0;
    m_reset();
    idle(0, 0);
    rd(10'h000);
    chk("post_rst_ctrl", last_rdata, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
